rr_packet_forwarder: RTL and testbench

Packet-level forwarding stage downstream of the 4-port round-robin arbiter. Drives the arbiter's `req` from the four requester channels and consumes its registered one-hot `grant`. Locks the granted port until that port's packet completes, forwarding its beats to a single shared valid/ready output. Gives the arbiter's beat-level grant packet atomicity, with a per-packet beat limit and protocol error flags.

---
 rtl/rr_packet_forwarder.sv | 127 ++++++++++++
 tb/tb_rr_packet_forwarder.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_packet_forwarder.sv
// rr_packet_forwarder: packet-atomic forwarding stage behind a 4-port
// round-robin arbiter. Requests are passed to the arbiter while idle. A
// usable grant locks one port, whose beats are forwarded to the shared
// output until the packet ends or reaches MAX_BEATS beats.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | req = in_valid, waiting for a usable one-hot grant
// LOCK  | owner port forwarded to the output, grant ignored
module rr_packet_forwarder #(
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          in_valid,
  input  logic [4*DATA_W-1:0] in_data,
  input  logic [3:0]          in_last,
  output logic [3:0]          in_ready,
  output logic [3:0]          req,
  input  logic [3:0]          grant,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic [1:0]          owner,
  output logic                busy,
  output logic                pkt_done,
  output logic                trunc,
  output logic                err_grant
);

  localparam int CNT_W = $clog2(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state, state_nxt;
  logic [3:0]       req_q;
  logic [1:0]       owner_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic             pkt_done_nxt, trunc_nxt, err_grant_nxt;
  logic [1:0]       grant_idx;
  logic             grant_onehot;
  logic             grant_ok;

  // Index of the (highest) set grant bit; only meaningful when one-hot.
  always_comb begin
    grant_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (grant[i]) grant_idx = 2'(i);
    end
  end

  // A grant is only trusted if we actually requested that port last cycle
  // and it still has a beat waiting; this also rejects stale post-LOCK grants.
  assign grant_onehot = (grant != 4'b0000) && ((grant & (grant - 4'd1)) == 4'b0000);
  assign grant_ok     = grant_onehot && req_q[grant_idx] && in_valid[grant_idx];

  assign busy = (state == LOCK);

  // Next-state, datapath steering and pulse generation.
  always_comb begin
    req           = 4'b0000;
    in_ready      = 4'b0000;
    out_valid     = 1'b0;
    out_data      = in_data[int'(owner)*DATA_W +: DATA_W];
    out_last      = 1'b0;
    state_nxt     = state;
    owner_nxt     = owner;
    beat_cnt_nxt  = beat_cnt;
    pkt_done_nxt  = 1'b0;
    trunc_nxt     = 1'b0;
    err_grant_nxt = 1'b0;
    case (state)
      IDLE: begin
        req = in_valid;
        if (grant != 4'b0000) begin
          if (grant_ok) begin
            state_nxt    = LOCK;
            owner_nxt    = grant_idx;
            beat_cnt_nxt = '0;
          end else begin
            err_grant_nxt = 1'b1;
          end
        end
      end
      LOCK: begin
        out_valid       = in_valid[owner];
        in_ready[owner] = out_ready;
        out_last        = in_last[owner] | (beat_cnt == CNT_LAST);
        if (out_valid && out_ready) begin
          if (out_last) begin
            state_nxt    = IDLE;
            pkt_done_nxt = 1'b1;
            trunc_nxt    = ~in_last[owner];
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, owner, beat counter, request history and registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_q     <= 4'b0000;
      owner     <= 2'd0;
      beat_cnt  <= '0;
      pkt_done  <= 1'b0;
      trunc     <= 1'b0;
      err_grant <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_q     <= req;
      owner     <= owner_nxt;
      beat_cnt  <= beat_cnt_nxt;
      pkt_done  <= pkt_done_nxt;
      trunc     <= trunc_nxt;
      err_grant <= err_grant_nxt;
    end
  end

endmodule

// File: tb/tb_rr_packet_forwarder.sv
// Bench for rr_packet_forwarder: per-port beat queues as sources, a
// behavioural round-robin arbiter, and a cycle model of the forwarding
// rules checked every cycle, plus packet-level pulse counts.
module tb_rr_packet_forwarder;
  localparam int DW    = 32;
  localparam int MB    = 4;
  localparam int DEPTH = 256;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      in_valid = '0;
  logic [4*DW-1:0] in_data = '0;
  logic [3:0]      in_last = '0;
  logic [3:0]      in_ready;
  logic [3:0]      req;
  logic [3:0]      grant = '0;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            out_ready = 1'b1;
  logic [1:0]      owner;
  logic            busy, pkt_done, trunc, err_grant;

  rr_packet_forwarder #(.DATA_W(DW), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .req(req), .grant(grant),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .owner(owner), .busy(busy), .pkt_done(pkt_done),
    .trunc(trunc), .err_grant(err_grant)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem_d [4][DEPTH];
  logic          mem_l [4][DEPTH];
  int            wr_p [4];
  int            rd_p [4];
  logic [3:0]    bub = '0;
  int            or_mode = 0;
  int            bub_pct = 0;
  int            force_pct = 0;
  logic          tog = 1'b0;

  bit            m_lock;
  int            m_owner, m_cnt;
  logic [3:0]    m_req_q;
  logic          m_pd, m_tr, m_eg;

  int            arb_ptr;
  logic [3:0]    arb_grant;
  logic          force_en = 1'b0;
  logic [3:0]    force_val = '0;

  logic          l_ov, l_ol, l_busy, l_pd, l_tr, l_eg;
  logic [1:0]    l_owner;
  logic [DW-1:0] l_data;
  int            n_pd = 0, n_tr = 0, n_acc = 0, n_last_acc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_pkt(input int port, input int len);
    for (int b = 0; b < len; b++) begin
      mem_d[port][wr_p[port]] = $urandom;
      mem_l[port][wr_p[port]] = (b == len - 1);
      wr_p[port]++;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (rd_p[i] < wr_p[i]) begin
        in_valid[i]            = ~bub[i];
        in_data[i*DW +: DW]    = mem_d[i][rd_p[i]];
        in_last[i]             = mem_l[i][rd_p[i]];
      end else begin
        in_valid[i]            = 1'b0;
        in_data[i*DW +: DW]    = '0;
        in_last[i]             = 1'b0;
      end
    end
    grant = force_en ? force_val : arb_grant;
  endtask

  task automatic model_reset();
    m_lock = 0; m_owner = 0; m_cnt = 0; m_req_q = '0;
    m_pd = 0; m_tr = 0; m_eg = 0;
    arb_ptr = 0; arb_grant = '0;
  endtask

  function automatic bit drained();
    for (int i = 0; i < 4; i++) if (rd_p[i] != wr_p[i]) return 0;
    return 1;
  endfunction

  // One clock cycle: check at the falling edge, advance at rising edge + 1.
  task automatic tick();
    logic [3:0]    e_req, e_rdy, arb_nxt, obs_req;
    logic          e_ov, e_ol;
    logic [DW-1:0] e_data;
    bit            acc, nx_lock;
    int            nx_owner, nx_cnt, nx_ptr, k, p;
    logic          nx_pd, nx_tr, nx_eg;
    logic [3:0]    nx_reqq;
    @(negedge clk);
    if (m_lock) begin
      e_req  = '0;
      e_ov   = in_valid[m_owner];
      e_rdy  = 4'(out_ready) << m_owner;
      e_data = in_data[m_owner*DW +: DW];
      e_ol   = in_last[m_owner] | (m_cnt == MB - 1);
    end else begin
      e_req = in_valid; e_ov = 0; e_rdy = '0; e_data = '0; e_ol = 0;
    end
    chk("req", req, e_req);
    chk("in_ready", in_ready, e_rdy);
    chk("out_valid", out_valid, e_ov);
    chk("out_last", out_last, e_ol);
    if (e_ov) chk("out_data", out_data, e_data);
    chk("busy", busy, m_lock);
    chk("owner", owner, m_owner[1:0]);
    chk("pkt_done", pkt_done, m_pd);
    chk("trunc", trunc, m_tr);
    chk("err_grant", err_grant, m_eg);
    l_ov = out_valid; l_ol = out_last; l_busy = busy; l_pd = pkt_done;
    l_tr = trunc; l_eg = err_grant; l_owner = owner; l_data = out_data;
    if (pkt_done === 1'b1) n_pd++;
    if (trunc === 1'b1) n_tr++;
    acc = m_lock && e_ov && out_ready;
    if (acc) begin
      n_acc++;
      if (e_ol) n_last_acc++;
    end
    obs_req = req;
    arb_nxt = '0;
    nx_ptr  = arb_ptr;
    if (rst_n) begin
      for (int j = 0; j < 4; j++) begin
        p = (arb_ptr + j) % 4;
        if (obs_req[p] === 1'b1 && arb_nxt == 4'b0000) begin
          arb_nxt[p] = 1'b1;
          nx_ptr = (p + 1) % 4;
        end
      end
    end
    nx_lock = m_lock; nx_owner = m_owner; nx_cnt = m_cnt;
    nx_pd = 0; nx_tr = 0; nx_eg = 0;
    nx_reqq = rst_n ? e_req : 4'b0000;
    if (!rst_n) begin
      nx_lock = 0; nx_owner = 0; nx_cnt = 0;
    end else if (m_lock) begin
      if (acc) begin
        if (e_ol) begin
          nx_lock = 0; nx_pd = 1; nx_tr = ~in_last[m_owner];
        end else begin
          nx_cnt = m_cnt + 1;
        end
      end
    end else if (grant != 4'b0000) begin
      k = -1;
      if ($countones(grant) == 1)
        for (int j = 0; j < 4; j++) if (grant[j]) k = j;
      if (k >= 0 && m_req_q[k] && in_valid[k]) begin
        nx_lock = 1; nx_owner = k; nx_cnt = 0;
      end else begin
        nx_eg = 1;
      end
    end
    @(posedge clk);
    #1;
    if (acc) rd_p[m_owner]++;
    m_lock = nx_lock; m_owner = nx_owner; m_cnt = nx_cnt; m_req_q = nx_reqq;
    m_pd = nx_pd; m_tr = nx_tr; m_eg = nx_eg;
    arb_grant = arb_nxt; arb_ptr = nx_ptr;
    tog = ~tog;
    for (int i = 0; i < 4; i++) bub[i] = ($urandom_range(0, 99) < bub_pct);
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = tog;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (force_pct > 0) begin
      force_en  = ($urandom_range(0, 99) < force_pct);
      force_val = 4'($urandom_range(1, 15));
    end
    drive();
  endtask

  task automatic run_until_idle(input string tag, input int bound);
    int n;
    n = 0;
    while (!(drained() && !m_lock) && n < bound) begin
      tick();
      n++;
    end
    chk(tag, drained() && !m_lock, 1);
    bub_pct = 0;
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    int base_pd, base_tr, base_acc, base_last, n, exp_segs, exp_tr, len;
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 4; i++) begin wr_p[i] = 0; rd_p[i] = 0; end
    model_reset();
    drive();
    #1;
    tick();
    tick();
    chk("rst_busy", l_busy, 0);
    chk("rst_out_valid", l_ov, 0);
    chk("rst_owner", l_owner, 0);
    chk("rst_pulses", {l_pd, l_tr, l_eg}, 3'b000);
    rst_n = 1'b1;

    // single-beat packet on port 2
    push_pkt(2, 1);
    exp_d = mem_d[2][0];
    drive();
    tick(); tick(); tick();
    chk("sb_out_valid", l_ov, 1);
    chk("sb_out_last", l_ol, 1);
    chk("sb_owner", l_owner, 2);
    chk("sb_data", l_data, exp_d);
    tick();
    chk("sb_pkt_done", l_pd, 1);
    chk("sb_busy", l_busy, 0);
    tick();

    // stalled 4-beat packet on port 0
    base_acc = n_acc; base_last = n_last_acc;
    or_mode = 1;
    push_pkt(0, 4);
    drive();
    run_until_idle("stall_timeout", 200);
    chk("stall_beats", n_acc - base_acc, 4);
    chk("stall_last_cnt", n_last_acc - base_last, 1);

    // round robin: every port holds 2-beat packets
    or_mode = 0;
    base_pd = n_pd;
    for (int r = 0; r < 2; r++) for (int i = 0; i < 4; i++) push_pkt(i, 2);
    drive();
    run_until_idle("rr_timeout", 400);
    chk("rr_pkt_cnt", n_pd - base_pd, 8);

    // truncation at MAX_BEATS
    base_pd = n_pd; base_tr = n_tr;
    push_pkt(1, 6);
    drive();
    run_until_idle("trunc_timeout", 200);
    chk("trunc_cnt", n_tr - base_tr, 1);
    chk("trunc_pkt_cnt", n_pd - base_pd, 2);

    // unusable grants in IDLE
    force_en = 1'b1; force_val = 4'b0011; drive();
    tick();
    force_en = 1'b0; drive();
    tick();
    chk("bad_multi_err", l_eg, 1);
    chk("bad_multi_busy", l_busy, 0);
    tick();
    chk("bad_err_one_cycle", l_eg, 0);
    force_en = 1'b1; force_val = 4'b1000; drive();
    tick();
    force_en = 1'b0; drive();
    tick();
    chk("bad_novalid_err", l_eg, 1);
    chk("bad_novalid_busy", l_busy, 0);
    tick();

    // reset after beat 2 of a 5-beat packet
    base_acc = n_acc;
    push_pkt(1, 5);
    drive();
    n = 0;
    while (n_acc - base_acc < 2 && n < 100) begin tick(); n++; end
    chk("mid_rst_reached", n_acc - base_acc, 2);
    rst_n = 1'b0;
    model_reset();
    rd_p[1] = wr_p[1];
    drive();
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_owner", l_owner, 0);
    chk("mid_rst_idle", l_busy, 0);

    // randomized traffic
    for (int i = 0; i < 4; i++) begin wr_p[i] = 0; rd_p[i] = 0; end
    exp_segs = 0; exp_tr = 0;
    for (int pk = 0; pk < 30; pk++) begin
      len = $urandom_range(1, 7);
      push_pkt($urandom_range(0, 3), len);
      exp_segs += (len + MB - 1) / MB;
      exp_tr   += (len + MB - 1) / MB - 1;
    end
    base_pd = n_pd; base_tr = n_tr;
    or_mode = 2; bub_pct = 25; force_pct = 3;
    drive();
    run_until_idle("rand_timeout", 20000);
    force_pct = 0; force_en = 1'b0; or_mode = 0;
    drive();
    tick(); tick();
    chk("rand_pkt_cnt", n_pd - base_pd, exp_segs);
    chk("rand_trunc_cnt", n_tr - base_tr, exp_tr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
